// File: rtl/pcap_irq_status_if.sv
// Bus between the PCAP sample writer / register block and the interrupt status stage.
// The master side drives the arm, sample and read strobes; the slave side returns the status record view.
interface pcap_irq_status_if #(
   parameter int FIFO_AW = 3
);
   logic               enable_i;
   logic               sample_valid_i;
   logic [15:0]        blocksize_i;
   logic [31:0]        timeout_i;
   logic               irq_rd_i;
   logic               irq_o;
   logic [31:0]        irq_status_o;
   logic [FIFO_AW:0]   fifo_count_o;
   logic               overflow_o;

   modport master (
      output enable_i, sample_valid_i, blocksize_i, timeout_i, irq_rd_i,
      input  irq_o, irq_status_o, fifo_count_o, overflow_o
   );

   modport slave (
      input  enable_i, sample_valid_i, blocksize_i, timeout_i, irq_rd_i,
      output irq_o, irq_status_o, fifo_count_o, overflow_o
   );
endinterface

// File: rtl/pcap_irq_status.sv
// Counts words written into the current DMA buffer, closes buffers on full/timeout/disarm,
// and queues one status record per closed buffer in a fall-through FIFO that drives the interrupt.
module pcap_irq_status #(
   parameter int FIFO_AW = 3
) (
   input logic                clk_i,
   input logic                reset_i,
   pcap_irq_status_if.slave   bus
);
   localparam int Depth = 2 ** FIFO_AW;

   logic                enable_q;
   logic [15:0]         cnt_q, cnt_d;
   logic [31:0]         tcnt_q, tcnt_d;
   logic                overflow_q, overflow_d;
   logic [FIFO_AW-1:0]  wptr_q, wptr_d;
   logic [FIFO_AW-1:0]  rptr_q, rptr_d;
   logic [FIFO_AW:0]    count_q, count_d;
   logic [31:0]         mem_q [Depth];

   logic                accept;
   logic                armStart;
   logic                disarm;
   logic                fullEv;
   logic                timeoutEv;
   logic                push;
   logic                pop;
   logic                fifoFull;
   logic                doWrite;
   logic [15:0]         cntBase;
   logic [16:0]         cntInc;
   logic [16:0]         blkLimit;
   logic [31:0]         record;

   assign accept   = bus.sample_valid_i & bus.enable_i;
   assign armStart = ~enable_q & bus.enable_i;
   assign disarm   = enable_q & ~bus.enable_i;
   assign cntBase  = armStart ? 16'd0 : cnt_q;
   assign cntInc   = {1'b0, cntBase} + 17'd1;
   assign blkLimit = (bus.blocksize_i == 16'd0) ? 17'd65535 : {1'b0, bus.blocksize_i};

   assign fullEv    = accept & (cntInc == blkLimit);
   assign timeoutEv = bus.enable_i & (bus.timeout_i != 32'd0) & (cntBase != 16'd0)
                    & ~accept & (tcnt_q == bus.timeout_i - 32'd1);

   // A full count never reaches the FIFO depth + 1, so the count MSB alone marks "full".
   assign pop      = bus.irq_rd_i & (count_q != '0);
   assign fifoFull = count_q[FIFO_AW];
   assign doWrite  = push & (~fifoFull | pop);

   always_comb begin
      push       = 1'b0;
      record     = 32'd0;
      cnt_d      = cntBase;
      tcnt_d     = armStart ? 32'd0 : tcnt_q;
      overflow_d = armStart ? 1'b0 : overflow_q;

      if (fullEv) begin
         push   = 1'b1;
         record = {cntInc[15:0], 16'h0004};
         cnt_d  = 16'd0;
         tcnt_d = 32'd0;
      end else if (timeoutEv) begin
         push   = 1'b1;
         record = {cntBase, 16'h0002};
         cnt_d  = 16'd0;
         tcnt_d = 32'd0;
      end else if (disarm) begin
         push   = 1'b1;
         record = {cntBase, 12'h000, overflow_q, 3'b001};
         cnt_d  = 16'd0;
         tcnt_d = 32'd0;
      end else if (accept) begin
         cnt_d  = cntInc[15:0];
         tcnt_d = 32'd0;
      end else if (bus.enable_i && cntBase != 16'd0) begin
         tcnt_d = tcnt_q + 32'd1;
      end

      if (push && !doWrite) begin
         overflow_d = 1'b1;
      end
   end

   always_comb begin
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q;
      if (doWrite) begin
         wptr_d = wptr_q + 1'b1;
      end
      if (pop) begin
         rptr_d = rptr_q + 1'b1;
      end
      if (doWrite && !pop) begin
         count_d = count_q + 1'b1;
      end else if (!doWrite && pop) begin
         count_d = count_q - 1'b1;
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         enable_q   <= 1'b0;
         cnt_q      <= 16'd0;
         tcnt_q     <= 32'd0;
         overflow_q <= 1'b0;
         wptr_q     <= '0;
         rptr_q     <= '0;
         count_q    <= '0;
      end else begin
         enable_q   <= bus.enable_i;
         cnt_q      <= cnt_d;
         tcnt_q     <= tcnt_d;
         overflow_q <= overflow_d;
         wptr_q     <= wptr_d;
         rptr_q     <= rptr_d;
         count_q    <= count_d;
      end
   end

   // Record storage needs no reset: an empty FIFO masks the head to zero.
   always_ff @(posedge clk_i) begin
      if (doWrite) begin
         mem_q[wptr_q] <= record;
      end
   end

   assign bus.irq_o        = (count_q != '0);
   assign bus.irq_status_o = (count_q != '0) ? mem_q[rptr_q] : 32'd0;
   assign bus.fifo_count_o = count_q;
   assign bus.overflow_o   = overflow_q;
endmodule

// File: tb/tb_pcap_irq_status.sv
// Bench for pcap_irq_status: directed vector table, multi-cycle corner sequences,
// and randomized traffic compared against a queue-based reference model.
module tb_pcap_irq_status;
   localparam int FifoAw = 3;
   localparam int Depth  = 8;

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;

   pcap_irq_status_if #(.FIFO_AW(FifoAw)) bus ();

   pcap_irq_status #(.FIFO_AW(FifoAw)) dut (
      .clk_i   (clk),
      .reset_i (reset),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   // Reference model: buffer word count, idle count, sticky overflow, and the record queue.
   int unsigned mCnt;
   int unsigned mTcnt;
   bit          mOvf;
   bit          mEnPrev;
   logic [31:0] mQ [$];

   typedef struct {
      bit          en;
      bit          sv;
      bit          rd;
      logic [15:0] bs;
      bit          expIrq;
      logic [31:0] expStatus;
      int          expCount;
      bit          expOvf;
   } vec_t;

   vec_t vecs [$];

   task automatic modelReset();
      mCnt    = 0;
      mTcnt   = 0;
      mOvf    = 1'b0;
      mEnPrev = 1'b0;
      mQ.delete();
   endtask

   task automatic modelStep();
      bit          en;
      bit          acc;
      bit          pushReq;
      bit          popOk;
      logic [31:0] rec;
      int unsigned limit;
      en      = bus.enable_i;
      acc     = bus.sample_valid_i && en;
      limit   = (bus.blocksize_i == 16'd0) ? 65535 : int'(bus.blocksize_i);
      pushReq = 1'b0;
      rec     = 32'd0;
      if (en && !mEnPrev) begin
         mCnt  = 0;
         mTcnt = 0;
         mOvf  = 1'b0;
      end
      if (acc && mCnt + 1 == limit) begin
         rec = {16'(mCnt + 1), 16'h0004};
         pushReq = 1'b1;
      end else if (en && bus.timeout_i != 0 && mCnt != 0 && !acc && mTcnt == bus.timeout_i - 32'd1) begin
         rec = {16'(mCnt), 16'h0002};
         pushReq = 1'b1;
      end else if (!en && mEnPrev) begin
         rec = {16'(mCnt), (mOvf ? 16'h0009 : 16'h0001)};
         pushReq = 1'b1;
      end else if (acc) begin
         mCnt  = mCnt + 1;
         mTcnt = 0;
      end else if (en && mCnt != 0) begin
         mTcnt = mTcnt + 1;
      end
      if (pushReq) begin
         mCnt  = 0;
         mTcnt = 0;
      end
      popOk = bus.irq_rd_i && mQ.size() != 0;
      if (popOk) void'(mQ.pop_front());
      if (pushReq) begin
         if (mQ.size() < Depth) mQ.push_back(rec);
         else mOvf = 1'b1;
      end
      mEnPrev = en;
   endtask

   task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic checkOutput(input string tag);
      logic [31:0] head;
      head = (mQ.size() != 0) ? mQ[0] : 32'd0;
      checkVal({tag, " irq"},    32'(bus.irq_o),        32'(mQ.size() != 0));
      checkVal({tag, " status"}, bus.irq_status_o,      head);
      checkVal({tag, " count"},  32'(bus.fifo_count_o), 32'(mQ.size()));
      checkVal({tag, " ovf"},    32'(bus.overflow_o),   32'(mOvf));
   endtask

   task automatic applyStimulus(input bit en, input bit sv, input bit rd);
      bus.enable_i       = en;
      bus.sample_valid_i = sv;
      bus.irq_rd_i       = rd;
      @(posedge clk);
      modelStep();
      #1;
   endtask

   task automatic doReset();
      bus.enable_i       = 1'b0;
      bus.sample_valid_i = 1'b0;
      bus.irq_rd_i       = 1'b0;
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      modelReset();
   endtask

   task automatic addVec(input bit en, input bit sv, input bit rd, input logic [15:0] bs,
                         input bit irq, input logic [31:0] st, input int cnt, input bit ovf);
      vec_t v;
      v.en = en; v.sv = sv; v.rd = rd; v.bs = bs;
      v.expIrq = irq; v.expStatus = st; v.expCount = cnt; v.expOvf = ovf;
      vecs.push_back(v);
   endtask

   initial begin
      reset              = 1'b1;
      bus.enable_i       = 1'b0;
      bus.sample_valid_i = 1'b0;
      bus.irq_rd_i       = 1'b0;
      bus.blocksize_i    = 16'd4;
      bus.timeout_i      = 32'd0;
      modelReset();
      #2;
      checkVal("reset irq",    32'(bus.irq_o),        32'd0);
      checkVal("reset status", bus.irq_status_o,      32'd0);
      checkVal("reset count",  32'(bus.fifo_count_o), 32'd0);
      checkVal("reset ovf",    32'(bus.overflow_o),   32'd0);
      doReset();

      // Full buffers at blocksize 4, drain, ignored samples while disarmed, empty-arm close.
      addVec(1,0,0,4, 0,32'h0,0,0);
      for (int i = 1; i <= 3; i++) addVec(1,1,0,4, 0,32'h0,0,0);
      for (int i = 4; i <= 7; i++) addVec(1,1,0,4, 1,32'h00040004,1,0);
      for (int i = 8; i <= 10; i++) addVec(1,1,0,4, 1,32'h00040004,2,0);
      addVec(0,0,0,4, 1,32'h00040004,3,0);
      addVec(0,0,1,4, 1,32'h00040004,2,0);
      addVec(0,0,1,4, 1,32'h00020001,1,0);
      addVec(0,0,1,4, 0,32'h0,0,0);
      addVec(0,0,1,4, 0,32'h0,0,0);
      addVec(0,1,0,1, 0,32'h0,0,0);
      addVec(0,1,0,1, 0,32'h0,0,0);
      addVec(1,0,0,1, 0,32'h0,0,0);
      addVec(0,0,0,1, 1,32'h00000001,1,0);
      addVec(0,0,1,1, 0,32'h0,0,0);
      foreach (vecs[i]) begin
         bus.blocksize_i = vecs[i].bs;
         applyStimulus(vecs[i].en, vecs[i].sv, vecs[i].rd);
         checkVal($sformatf("vec%0d irq", i),    32'(bus.irq_o),        32'(vecs[i].expIrq));
         checkVal($sformatf("vec%0d status", i), bus.irq_status_o,      vecs[i].expStatus);
         checkVal($sformatf("vec%0d count", i),  32'(bus.fifo_count_o), 32'(vecs[i].expCount));
         checkVal($sformatf("vec%0d ovf", i),    32'(bus.overflow_o),   32'(vecs[i].expOvf));
      end

      // Timeout: the partial buffer closes 50 idle clocks after the last sample.
      doReset();
      bus.blocksize_i = 16'd100;
      bus.timeout_i   = 32'd50;
      applyStimulus(1, 0, 0);
      repeat (3) applyStimulus(1, 1, 0);
      repeat (49) applyStimulus(1, 0, 0);
      checkVal("timeout early count", 32'(bus.fifo_count_o), 32'd0);
      applyStimulus(1, 0, 0);
      checkVal("timeout count",  32'(bus.fifo_count_o), 32'd1);
      checkVal("timeout record", bus.irq_status_o,      32'h00030002);
      applyStimulus(0, 0, 1);
      checkVal("timeout disarm record", bus.irq_status_o, 32'h00000001);
      checkOutput("timeout end");
      applyStimulus(0, 0, 1);
      bus.timeout_i = 32'd0;

      // Overflow: blocksize 1, ten samples with no pops, then drain and re-arm.
      doReset();
      bus.blocksize_i = 16'd1;
      applyStimulus(1, 0, 0);
      repeat (10) applyStimulus(1, 1, 0);
      checkVal("ovf count", 32'(bus.fifo_count_o), 32'd8);
      checkVal("ovf flag",  32'(bus.overflow_o),   32'd1);
      applyStimulus(0, 0, 0);
      checkVal("ovf disarm dropped", 32'(bus.fifo_count_o), 32'd8);
      repeat (8) applyStimulus(0, 0, 1);
      checkVal("ovf drained irq",    32'(bus.irq_o),      32'd0);
      checkVal("ovf sticky disarmed", 32'(bus.overflow_o), 32'd1);
      applyStimulus(1, 0, 0);
      checkVal("ovf rearm clear",    32'(bus.overflow_o), 32'd0);
      applyStimulus(0, 0, 0);
      checkOutput("ovf end");

      // Overflow flag carried in the COMPLETED record.
      doReset();
      bus.blocksize_i = 16'd1;
      applyStimulus(1, 0, 0);
      repeat (10) applyStimulus(1, 1, 0);
      applyStimulus(1, 0, 1);
      checkVal("ovfrec count after pop", 32'(bus.fifo_count_o), 32'd7);
      applyStimulus(0, 0, 0);
      repeat (7) applyStimulus(0, 0, 1);
      checkVal("ovfrec last record", bus.irq_status_o, 32'h00000009);
      checkVal("ovfrec last count",  32'(bus.fifo_count_o), 32'd1);

      // Push and pop together while full keeps the count and the order.
      doReset();
      bus.blocksize_i = 16'd1;
      applyStimulus(1, 0, 0);
      repeat (8) applyStimulus(1, 1, 0);
      applyStimulus(0, 0, 1);
      checkVal("fullpp count", 32'(bus.fifo_count_o), 32'd8);
      checkVal("fullpp ovf",   32'(bus.overflow_o),   32'd0);
      checkVal("fullpp head",  bus.irq_status_o,      32'h00010004);
      repeat (7) applyStimulus(0, 0, 1);
      checkVal("fullpp tail",  bus.irq_status_o,      32'h00000001);
      applyStimulus(0, 0, 1);

      // Asynchronous reset mid-arm; no COMPLETED record afterwards.
      doReset();
      bus.blocksize_i = 16'd2;
      applyStimulus(1, 0, 0);
      repeat (5) applyStimulus(1, 1, 0);
      #2;
      reset = 1'b1;
      bus.enable_i = 1'b0;
      bus.sample_valid_i = 1'b0;
      #1;
      checkVal("areset irq",    32'(bus.irq_o),        32'd0);
      checkVal("areset status", bus.irq_status_o,      32'd0);
      checkVal("areset count",  32'(bus.fifo_count_o), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      modelReset();
      repeat (3) applyStimulus(0, 0, 0);
      checkVal("areset nothing queued", 32'(bus.fifo_count_o), 32'd0);

      // blocksize 0 behaves as 65535 words.
      doReset();
      bus.blocksize_i = 16'd0;
      applyStimulus(1, 0, 0);
      repeat (65534) applyStimulus(1, 1, 0);
      checkVal("bs0 not yet full", 32'(bus.fifo_count_o), 32'd0);
      applyStimulus(1, 1, 0);
      checkVal("bs0 full record", bus.irq_status_o, 32'hFFFF0004);
      applyStimulus(0, 0, 1);
      applyStimulus(0, 0, 1);
      checkOutput("bs0 end");

      // Randomized traffic against the reference model.
      doReset();
      bus.blocksize_i = 16'd3;
      bus.timeout_i   = 32'd4;
      begin
         bit en = 1'b0;
         for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 29) == 0) en = ~en;
            if ($urandom_range(0, 99) == 0) bus.blocksize_i = 16'($urandom_range(1, 6));
            if ($urandom_range(0, 99) == 0) bus.timeout_i = ($urandom_range(0, 2) == 0) ? 32'd0 : 32'($urandom_range(2, 9));
            applyStimulus(en, $urandom_range(0, 2) == 0, $urandom_range(0, 4) == 0);
            checkOutput($sformatf("rand%0d", i));
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
